// File: rtl/mmio_responder.sv
// mmio_responder
//   Data-side MMIO responder for the pipelined RV32 core. It answers load/store
//   requests that fall in a 256-byte window with a fixed latency. The window
//   holds a tohost exit register, a 64-bit free-running cycle counter (read
//   coherently as lo then hi) and a small console byte FIFO. The FIFO drains
//   one byte every DRAIN_DIV cycles to a byte output.
// Ports:
//   clk_i, reset_i          clock; synchronous active-high reset
//   req_valid_i, req_we_i   request present / store(1) or load(0)
//   req_addr_i, req_wdata_i byte address (word aligned), store data
//   req_ready_o             one-cycle response pulse
//   req_rdata_o, req_err_o  load data / decode error, valid with req_ready_o
//   done_o, exit_code_o     sticky completion flag and tohost wdata[31:1]
//   cons_valid_o, cons_byte_o  one-cycle console byte pulse and its byte
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DRAIN_DIV  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic [31:0] req_rdata_o,
  output logic        req_err_o,
  output logic        done_o,
  output logic [30:0] exit_code_o,
  output logic        cons_valid_o,
  output logic [7:0]  cons_byte_o
);

  localparam int unsigned        PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned        CNT_W      = PTR_W + 1;
  localparam logic [3:0]         WAIT_INIT  = 4'(LATENCY - 1);
  localparam logic [7:0]         DRAIN_LAST = 8'(DRAIN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);

  localparam logic [7:0] OFF_TOHOST   = 8'h00;
  localparam logic [7:0] OFF_CONS     = 8'h04;
  localparam logic [7:0] OFF_STATUS   = 8'h08;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h10;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_STALL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         wait_q, wait_d;
  logic               we_q;
  logic [31:0]        addr_q, wdata_q;
  logic [63:0]        cycle_q, cycle_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        tohost_q, tohost_d;
  logic               done_q, done_d;
  logic [30:0]        exit_q, exit_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         drain_q, drain_d;
  logic               req_ready_q, req_ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               cons_valid_q, cons_valid_d;
  logic [7:0]         cons_byte_q, cons_byte_d;

  logic               cur_we_s;
  logic [31:0]        cur_addr_s, cur_wdata_s;
  logic               in_win_s, mapped_s, cons_wr_s, full_s, pop_s, stall_s;
  logic               enter_s, resp_go_s, push_s;
  logic [7:0]         off_s;

  // Decoder source: live inputs while IDLE (LATENCY=1 responds straight from IDLE), captured copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we_s    = req_we_i;
      cur_addr_s  = req_addr_i;
      cur_wdata_s = req_wdata_i;
    end else begin
      cur_we_s    = we_q;
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
    end
  end

  assign off_s     = cur_addr_s[7:0];
  assign in_win_s  = (cur_addr_s[31:8] == BASE_ADDR[31:8]);
  assign mapped_s  = (off_s == OFF_TOHOST) || (off_s == OFF_CONS) || (off_s == OFF_STATUS) ||
                     (off_s == OFF_CYCLE_LO) || (off_s == OFF_CYCLE_HI);
  assign cons_wr_s = cur_we_s && in_win_s && (off_s == OFF_CONS);
  assign full_s    = (count_q == CNT_FULL);
  assign pop_s     = (drain_q == DRAIN_LAST) && (count_q != CNT_ZERO);
  // A console push into a full FIFO waits, unless a pop frees an entry on the same edge.
  assign stall_s   = cons_wr_s && full_s && !pop_s;
  assign resp_go_s = enter_s && !stall_s;

  // FSM state register and request capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

  // FSM next-state logic; enter_s marks an edge that tries to move into RESP.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    enter_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          wait_d = WAIT_INIT;
          if (LATENCY == 32'd1) begin
            enter_s = 1'b1;
            state_d = stall_s ? S_STALL : S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          enter_s = 1'b1;
          state_d = stall_s ? S_STALL : S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_STALL: begin
        enter_s = 1'b1;
        state_d = stall_s ? S_STALL : S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and side-effect logic, evaluated on the edge that enters RESP so the
  // response registers hold values that match the RESP cycle itself.
  always_comb begin
    cycle_d      = cycle_q + 64'd1;
    shadow_d     = shadow_q;
    tohost_d     = tohost_q;
    done_d       = done_q;
    exit_d       = exit_q;
    push_s       = resp_go_s && cons_wr_s;
    count_d      = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    head_d       = pop_s  ? head_q + PTR_ONE : head_q;
    tail_d       = push_s ? tail_q + PTR_ONE : tail_q;
    drain_d      = (drain_q == DRAIN_LAST) ? 8'd0 : drain_q + 8'd1;
    cons_valid_d = pop_s;
    cons_byte_d  = pop_s ? fifo_mem_q[head_q] : cons_byte_q;
    req_ready_d  = resp_go_s;
    err_d        = 1'b0;
    rdata_d      = 32'd0;
    if (resp_go_s) begin
      if (!in_win_s || !mapped_s) begin
        err_d = 1'b1;
      end else if (cur_we_s) begin
        if (off_s == OFF_TOHOST && cur_wdata_s != 32'd0) begin
          tohost_d = cur_wdata_s;
          done_d   = 1'b1;
          exit_d   = cur_wdata_s[31:1];
        end else begin
          tohost_d = tohost_q;
        end
      end else begin
        case (off_s)
          OFF_TOHOST:   rdata_d = tohost_q;
          OFF_STATUS:   rdata_d = {27'd0, 4'(count_d), (count_d == CNT_FULL)};
          OFF_CYCLE_LO: begin
            rdata_d  = cycle_d[31:0];
            shadow_d = cycle_d[63:32];
          end
          OFF_CYCLE_HI: rdata_d = shadow_q;
          default:      rdata_d = 32'd0;
        endcase
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Datapath registers: counter, shadow, tohost, FIFO control and response outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_q      <= 64'd0;
      shadow_q     <= 32'd0;
      tohost_q     <= 32'd0;
      done_q       <= 1'b0;
      exit_q       <= 31'd0;
      head_q       <= PTR_W'(0);
      tail_q       <= PTR_W'(0);
      count_q      <= CNT_ZERO;
      drain_q      <= 8'd0;
      req_ready_q  <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      cons_valid_q <= 1'b0;
      cons_byte_q  <= 8'd0;
    end else begin
      cycle_q      <= cycle_d;
      shadow_q     <= shadow_d;
      tohost_q     <= tohost_d;
      done_q       <= done_d;
      exit_q       <= exit_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      drain_q      <= drain_d;
      req_ready_q  <= req_ready_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cons_valid_q <= cons_valid_d;
      cons_byte_q  <= cons_byte_d;
    end
  end

  // Console FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk_i) begin
    if (push_s && !reset_i) begin
      fifo_mem_q[tail_q] <= cur_wdata_s[7:0];
    end
  end

  assign req_ready_o  = req_ready_q;
  assign req_rdata_o  = rdata_q;
  assign req_err_o    = err_q;
  assign done_o       = done_q;
  assign exit_code_o  = exit_q;
  assign cons_valid_o = cons_valid_q;
  assign cons_byte_o  = cons_byte_q;

endmodule
